// File: rtl/data_ram_pkg.sv
// Shared constants, FSM encoding and helpers for the data_ram_ctrl load/store memory.
package data_ram_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 6;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned LANES          = DEFAULT_DATA_W / 8;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 2;

  localparam logic [DEFAULT_DATA_W-1:0] RESET_VAL_DEFAULT = '0;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic int unsigned lanes_of(input int unsigned data_w);
    return data_w / 8;
  endfunction

  function automatic bit read_lat_legal(input int unsigned lat);
    return (lat == READ_LAT_MIN) || (lat == READ_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_core.sv
// Storage array with byte-lane writes and the first (read-first) read register.
module ram_core
  import data_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned       BE_W      = LANES,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [BE_W-1:0]   be_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto block RAM; clearing is done by the controller's sweep.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= RESET_VAL;
    else if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// Load/store data RAM controller: handshake, clear sweep (macro RAM_CLEAR_EN) and 1/2-cycle read pipeline.
module data_ram_ctrl
  import data_ram_pkg::*;
#(
  parameter int unsigned       ADDR_W    = DEFAULT_ADDR_W,
  parameter int unsigned       DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned       READ_LAT  = READ_LAT_MIN,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEFAULT)
) (
  input  logic                clka,
  input  logic                rsta,
  input  logic                req,
  input  logic                wea,
  input  logic [DATA_W/8-1:0] bea,
  input  logic [ADDR_W-1:0]   addra,
  input  logic [DATA_W-1:0]   dina,
  output logic                ready,
  output logic [DATA_W-1:0]   douta,
  output logic                rvalid,
  output logic                busy
);

  localparam int unsigned NLANES = lanes_of(DATA_W);

  if (!read_lat_legal(READ_LAT)) begin : g_bad_lat
    $error("data_ram_ctrl: READ_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : g_bad_width
    $error("data_ram_ctrl: DATA_W must be a multiple of 8");
  end

`ifdef RAM_CLEAR_EN
  localparam state_e RESET_STATE = CLEAR;
  logic [ADDR_W-1:0] clr_cnt_q;
`else
  localparam state_e RESET_STATE = RUN;
`endif

  state_e              state_q, state_d;
  logic                core_we, core_re;
  logic [NLANES-1:0]   core_be;
  logic [ADDR_W-1:0]   core_addr;
  logic [DATA_W-1:0]   core_wdata, core_rdata;
  logic                valid1_q;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    ready      = 1'b0;
    busy       = 1'b0;
    core_we    = 1'b0;
    core_re    = 1'b0;
    core_be    = bea;
    core_addr  = addra;
    core_wdata = dina;
    case (state_q)
      RUN: begin
        // rsta gating keeps an access on the reset edge from committing.
        ready   = !rsta;
        core_we = req && wea && !rsta;
        core_re = req && !wea && !rsta;
      end
`ifdef RAM_CLEAR_EN
      CLEAR: begin
        busy       = 1'b1;
        core_we    = !rsta;
        core_be    = '1;
        core_addr  = clr_cnt_q;
        core_wdata = RESET_VAL;
        if (&clr_cnt_q) state_d = RUN;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q  <= RESET_STATE;
      valid1_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid1_q <= core_re;
    end
  end

`ifdef RAM_CLEAR_EN
  always_ff @(posedge clka) begin
    if (rsta)                 clr_cnt_q <= '0;
    else if (state_q == CLEAR) clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
  end
`endif

  ram_core #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .BE_W     (NLANES),
    .RESET_VAL(RESET_VAL)
  ) u_core (
    .clk_i  (clka),
    .rst_i  (rsta),
    .we_i   (core_we),
    .be_i   (core_be),
    .re_i   (core_re),
    .addr_i (core_addr),
    .wdata_i(core_wdata),
    .rdata_o(core_rdata)
  );

  if (READ_LAT == 2) begin : g_lat2
    logic              valid2_q;
    logic [DATA_W-1:0] dout2_q;
    always_ff @(posedge clka) begin
      if (rsta) begin
        valid2_q <= 1'b0;
        dout2_q  <= RESET_VAL;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) dout2_q <= core_rdata;
      end
    end
    assign rvalid = valid2_q;
    assign douta  = dout2_q;
  end else begin : g_lat1
    assign rvalid = valid1_q;
    assign douta  = core_rdata;
  end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench: READ_LAT=1 and READ_LAT=2 instances share one stimulus stream and one reference model.
`timescale 1ns/1ps
module tb_data_ram_ctrl;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
`ifdef RAM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rsta, req, wea;
  logic [3:0]    bea;
  logic [AW-1:0] addra;
  logic [DW-1:0] dina;
  logic          ready1, rvalid1, busy1, ready2, rvalid2, busy2;
  logic [DW-1:0] dout1, dout2;

  data_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .RESET_VAL(32'h0)) dut1 (
    .clka(clk), .rsta(rsta), .req(req), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .ready(ready1), .douta(dout1), .rvalid(rvalid1), .busy(busy1)
  );

  data_ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(2), .RESET_VAL(32'h0)) dut2 (
    .clka(clk), .rsta(rsta), .req(req), .wea(wea), .bea(bea), .addra(addra), .dina(dina),
    .ready(ready2), .douta(dout2), .rvalid(rvalid2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: word array, remaining clear cycles, and per-latency expected outputs.
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = 0;
  bit            chk_en = 1'b0;
  bit            m_v1 = 1'b0, m_v2 = 1'b0, prev_ok = 1'b0;
  logic [DW-1:0] m_d1 = '0, m_d2 = '0, prev_data = '0;

  // One clock cycle: drive at the falling edge, check ready/busy, model the rising edge, check read outputs.
  task automatic step(input bit r, input bit w, input logic [3:0] b, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit rs);
    bit            exp_ready, exp_busy, acc, rd_ok;
    logic [DW-1:0] rd_data;
    req = r; wea = w; bea = b; addra = a; dina = d; rsta = rs;
    exp_busy  = (clear_left > 0);
    exp_ready = !rs && !exp_busy;
    #1;
    if (chk_en) begin
      vectors++;
      if (ready1 !== exp_ready || ready2 !== exp_ready) begin
        miscompares++;
        $display("FAIL ready: got %b/%b expected %b at %0t", ready1, ready2, exp_ready, $time);
      end
      vectors++;
      if (busy1 !== exp_busy || busy2 !== exp_busy) begin
        miscompares++;
        $display("FAIL busy: got %b/%b expected %b at %0t", busy1, busy2, exp_busy, $time);
      end
    end
    @(posedge clk);
    if (rs) begin
      clear_left = CLEAR_EN ? DEPTH : 0;
      if (CLEAR_EN) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      m_v1 = 1'b0; m_v2 = 1'b0; m_d1 = '0; m_d2 = '0; prev_ok = 1'b0;
    end else begin
      acc     = r && exp_ready;
      m_v2    = prev_ok;
      if (prev_ok) m_d2 = prev_data;
      rd_ok   = acc && !w;
      rd_data = ref_mem[a];
      m_v1    = rd_ok;
      if (rd_ok) m_d1 = rd_data;
      if (acc && w)
        for (int i = 0; i < 4; i++) if (b[i]) ref_mem[a][8*i +: 8] = d[8*i +: 8];
      if (clear_left > 0) clear_left--;
      prev_ok   = rd_ok;
      prev_data = rd_data;
    end
    chk_en = 1'b1;
    @(negedge clk);
    vectors++;
    if (rvalid1 !== m_v1) begin
      miscompares++;
      $display("FAIL rvalid_lat1: got %b expected %b at %0t", rvalid1, m_v1, $time);
    end
    vectors++;
    if (dout1 !== m_d1) begin
      miscompares++;
      $display("FAIL douta_lat1: got %h expected %h at %0t", dout1, m_d1, $time);
    end
    vectors++;
    if (rvalid2 !== m_v2) begin
      miscompares++;
      $display("FAIL rvalid_lat2: got %b expected %b at %0t", rvalid2, m_v2, $time);
    end
    vectors++;
    if (dout2 !== m_d2) begin
      miscompares++;
      $display("FAIL douta_lat2: got %h expected %h at %0t", dout2, m_d2, $time);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 4'h0, '0, '0, 1'b1);
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) idle();
    #1;
    vectors++;
    if (ready1 !== 1'b1 || busy1 !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_after_clear: got ready=%b busy=%b expected ready=1 busy=0", ready1, busy1);
    end
    step(1'b1, 1'b0, 4'h0, 6'd0, '0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd31, '0, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd63, '0, 1'b0);
    vectors++;
    if (rvalid1 !== 1'b1 || dout1 !== 32'h0) begin
      miscompares++;
      $display("FAIL clear_read_63: got rvalid=%b douta=%h expected rvalid=1 douta=00000000", rvalid1, dout1);
    end
    idle();
    idle();
`else
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, 4'hF, AW'(i), $urandom, 1'b0);
`endif
  endtask

  task automatic test_byte_write();
    step(1'b1, 1'b1, 4'hF,    6'd5, 32'hAABBCCDD, 1'b0);
    step(1'b1, 1'b1, 4'b0101, 6'd5, 32'h11223344, 1'b0);
    step(1'b1, 1'b0, 4'h0,    6'd5, '0,           1'b0);
    vectors++;
    if (rvalid1 !== 1'b1 || dout1 !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL byte_write_lat1: got rvalid=%b douta=%h expected rvalid=1 douta=aa22cc44", rvalid1, dout1);
    end
    idle();
    vectors++;
    if (rvalid2 !== 1'b1 || dout2 !== 32'hAA22CC44) begin
      miscompares++;
      $display("FAIL byte_write_lat2: got rvalid=%b douta=%h expected rvalid=1 douta=aa22cc44", rvalid2, dout2);
    end
  endtask

  task automatic test_bea_zero();
    step(1'b1, 1'b1, 4'hF, 6'd7, 32'h12345678, 1'b0);
    step(1'b1, 1'b1, 4'h0, 6'd7, 32'hFFFFFFFF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd7, '0,           1'b0);
    vectors++;
    if (dout1 !== 32'h12345678) begin
      miscompares++;
      $display("FAIL bea_zero_noop: got %h expected 12345678", dout1);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b1, 4'hF, 6'd1, 32'hA1A1A1A1, 1'b0);
    step(1'b1, 1'b1, 4'hF, 6'd2, 32'hB2B2B2B2, 1'b0);
    step(1'b1, 1'b1, 4'hF, 6'd3, 32'hC3C3C3C3, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd1, '0, 1'b0);
    vectors++;
    if (rvalid2 !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_early: got rvalid=%b expected 0", rvalid2);
    end
    step(1'b1, 1'b0, 4'h0, 6'd2, '0, 1'b0);
    vectors++;
    if (rvalid2 !== 1'b1 || dout2 !== 32'hA1A1A1A1) begin
      miscompares++;
      $display("FAIL b2b_first: got rvalid=%b douta=%h expected 1 a1a1a1a1", rvalid2, dout2);
    end
    step(1'b1, 1'b0, 4'h0, 6'd3, '0, 1'b0);
    vectors++;
    if (rvalid2 !== 1'b1 || dout2 !== 32'hB2B2B2B2) begin
      miscompares++;
      $display("FAIL b2b_second: got rvalid=%b douta=%h expected 1 b2b2b2b2", rvalid2, dout2);
    end
    idle();
    vectors++;
    if (rvalid2 !== 1'b1 || dout2 !== 32'hC3C3C3C3) begin
      miscompares++;
      $display("FAIL b2b_third: got rvalid=%b douta=%h expected 1 c3c3c3c3", rvalid2, dout2);
    end
    idle();
    vectors++;
    if (rvalid2 !== 1'b0 || dout2 !== 32'hC3C3C3C3) begin
      miscompares++;
      $display("FAIL b2b_hold: got rvalid=%b douta=%h expected 0 c3c3c3c3", rvalid2, dout2);
    end
  endtask

  task automatic test_write_then_read();
    step(1'b1, 1'b1, 4'hF, 6'd9, 32'hDEADBEEF, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd9, '0,           1'b0);
    vectors++;
    if (rvalid1 !== 1'b1 || dout1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL write_then_read: got rvalid=%b douta=%h expected 1 deadbeef", rvalid1, dout1);
    end
    idle();
  endtask

  task automatic test_reset_midflight();
    logic [DW-1:0] exp3;
`ifdef RAM_CLEAR_EN
    exp3 = 32'h0;
`else
    exp3 = 32'h5;
`endif
    step(1'b1, 1'b1, 4'hF, 6'd3, 32'h5, 1'b0);
    step(1'b1, 1'b0, 4'h0, 6'd9, '0,    1'b0);
    step(1'b0, 1'b0, 4'h0, '0,   '0,    1'b1);
    vectors++;
    if (rvalid2 !== 1'b0 || dout2 !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_midflight: got rvalid=%b douta=%h expected 0 00000000", rvalid2, dout2);
    end
    idle();
`ifdef RAM_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) idle();
`endif
    step(1'b1, 1'b0, 4'h0, 6'd3, '0, 1'b0);
    vectors++;
    if (rvalid1 !== 1'b1 || dout1 !== exp3) begin
      miscompares++;
      $display("FAIL read_after_reset: got rvalid=%b douta=%h expected 1 %h", rvalid1, dout1, exp3);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom),
           AW'($urandom_range(0, 15)), $urandom, $urandom_range(0, 199) == 0);
    end
    idle();
    idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rsta = 1'b1; req = 1'b0; wea = 1'b0; bea = '0; addra = '0; dina = '0;
    @(negedge clk);
    test_reset();
    test_byte_write();
    test_bea_zero();
    test_back_to_back();
    test_write_then_read();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_ram_ctrl.md
Name: data_ram_ctrl

Overview:
- Parametrised single-port data memory for the microprocessor's load/store path; next generation of the fixed 64x32 word-only RAM.
- Adds configurable width and depth, byte-lane write enables, and a selectable registered read latency.
- Adds a req/ready/rvalid handshake toward the LSU and a power-on clear sequencer.
- Sits between the load/store unit and the on-chip block RAM.

Parameters:
- ADDR_W, 6, word address width; DEPTH = 2**ADDR_W words.
- DATA_W, 32, word width; must be a multiple of 8.
- READ_LAT, 1, read latency in cycles; legal values 1 or 2. Any other value fails at elaboration.
- RESET_VAL, 0, value driven on douta during reset and clear.

Ports:
- clka  in  1  single clock; all logic on the rising edge.
- rsta  in  1  synchronous, active-high reset.
- req  in  1  access request.
- wea  in  1  1 = write, 0 = read; qualifies req.
- bea  in  DATA_W/8  byte-lane write enables; ignored on reads.
- addra  in  ADDR_W  word address.
- dina  in  DATA_W  write data.
- ready  out  1  block can accept a request this cycle.
- douta  out  DATA_W  read data; valid only while rvalid = 1.
- rvalid  out  1  one-cycle pulse marking read data on douta.
- busy  out  1  clear sweep in progress.

Behaviour:
- Reset values: ready=0, rvalid=0, douta=RESET_VAL, busy=1 (with RAM_CLEAR_EN) or 0 (without). Read pipeline flushed.
- Reset asserted mid-operation:
  - In-flight reads are dropped; no rvalid follows.
  - A write accepted on the same edge as rsta=1 is not committed.
- FSM states: CLEAR, RUN.
  - rsta=1 forces CLEAR (with RAM_CLEAR_EN) or RUN (without).
  - CLEAR: an ADDR_W-bit counter starts at 0 and writes RESET_VAL to one word per cycle; busy=1, ready=0.
  - CLEAR → RUN on the cycle after the write to address DEPTH-1; the sweep takes exactly DEPTH cycles.
  - RUN: ready=1 continuously; busy=0.
- Acceptance: a request is accepted at an edge where req=1 and ready=1. No back-pressure in RUN; one access per cycle, back-to-back allowed.
- Writes:
  - Committed at the accepting edge. For each lane i with bea[i]=1, mem[addra][8i+7:8i] ← dina[8i+7:8i]; lanes with bea[i]=0 are unchanged.
  - A write with bea=0 is accepted and is a no-op.
  - Writes never produce rvalid.
- Reads:
  - READ_LAT=1: the array output is registered once; douta and rvalid appear on the cycle after acceptance.
  - READ_LAT=2: an extra output register stage; douta and rvalid appear two cycles after acceptance.
  - rvalid is 1 for exactly one cycle per accepted read. douta holds its last value while rvalid=0.
- Read-during-write, same address, consecutive cycles: the read sees the newly written data.
- Single-port rule: a request is either a read or a write. Write mode is read-first, but a write's old data is not returned (writes never produce rvalid).
- Address wrap: the clear counter wraps to 0 only on reset; the full address space is always legal.

Optional Feature:
- Macro RAM_CLEAR_EN.
- Defined: the CLEAR sweep runs after every reset, and all words read RESET_VAL afterwards.
- Undefined: the CLEAR state is removed, busy is tied to 0, and ready=1 on the first cycle after reset deasserts. Memory contents persist across reset; undefined at power-up.

Decomposition:
- Package data_ram_pkg:
  - Lane-count constant, DATA_W/8.
  - Legal READ_LAT values.
  - FSM state enum {CLEAR, RUN}.
  - RESET_VAL default.
- Sub-module ram_core: storage array plus byte-lane write and the first read register only. Handshake, FSM, clear counter and latency pipeline stay in data_ram_ctrl.

Test Plan:
- Clear (RAM_CLEAR_EN, ADDR_W=6): deassert rsta → busy=1 for exactly 64 cycles, then ready=1; reading addresses 0, 31, 63 returns 0.
- Byte write: write 0xAABBCCDD to address 5 with bea=4'hF, then 0x11223344 with bea=4'b0101 → read 5 returns 0xAA22CC44.
- Latency, READ_LAT=2: back-to-back reads of addresses 1, 2, 3 at cycles t, t+1, t+2 → rvalid at t+2, t+3, t+4 with the matching data in order.
- Write then read: write 0xDEADBEEF to address 9 at cycle t, read 9 at t+1 → douta=0xDEADBEEF with rvalid at t+2 (READ_LAT=1).
- Reset mid-flight: accept a read at t, assert rsta at t+1 (READ_LAT=2) → no rvalid at t+2, douta=RESET_VAL.
- Without RAM_CLEAR_EN: write 0x5 to address 3, pulse rsta → ready=1 on the first cycle after rsta deasserts, busy stays 0, read 3 returns 0x5.
